mem_load_ctrl: RTL

//  Byte-stream loader that sequences writes into the 102-byte configuration memory.

---
 rtl/mem_load_ctrl_pkg.sv | 18 +
 rtl/mem_load_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_load_ctrl_pkg.sv
// Shared constants and state encoding for the configuration-memory byte loader.
// Frame layout: address byte, length byte, then the payload bytes.
package mem_load_ctrl_pkg;

    localparam int NUM_BYTES    = 102;
    localparam int HDR_ADDR_OFS = 0;
    localparam int HDR_LEN_OFS  = 1;
    localparam int HDR_BYTES    = 2;

    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_LEN   = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_load_ctrl.sv
// Turns framed host bytes {A, L, payload...} into registered memory write cycles.
// Out-of-range frames are drained without writing and raise the sticky err flag.
module mem_load_ctrl #(
    parameter int NUM_BYTES = mem_load_ctrl_pkg::NUM_BYTES,
    parameter int AW        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [AW-1:0]             mem_addr,
    output logic [7:0]                mem_data,
    output logic                      mem_we,
    output logic                      frame_done,
    output logic                      cfg_loaded,
    output logic                      err,
    input  logic                      clr_err,
    output logic                      busy,
    output mem_load_ctrl_pkg::state_t dbg_state
);
    import mem_load_ctrl_pkg::*;

    // Handshake: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready is a pure function of state and never looks at in_valid.

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [7:0]    rem_q;
    logic          frame_ok_q;
    logic          xfer;
    logic [8:0]    end_sum;
    logic          range_err;

    assign xfer      = in_valid && in_ready;
    assign end_sum   = 9'(addr_q) + 9'(in_data);
    assign range_err = (9'(addr_q) >= 9'(NUM_BYTES)) || (end_sum > 9'(NUM_BYTES));
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ADDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b1;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            S_ADDR: begin
                busy = 1'b0;
                if (in_valid) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (in_valid) begin
                    if (in_data == 8'd0)  state_nxt = S_DONE;
                    else if (range_err)   state_nxt = S_DRAIN;
                    else                  state_nxt = S_LOAD;
                end
            end
            S_LOAD, S_DRAIN: begin
                if (in_valid && rem_q == 8'd1) state_nxt = S_DONE;
            end
            S_DONE: begin
                in_ready   = 1'b0;
                frame_done = 1'b1;
                state_nxt  = S_ADDR;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            frame_ok_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cfg_loaded <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_ADDR: begin
                    if (xfer) addr_q <= AW'(in_data);
                end
                S_LEN: begin
                    if (xfer) begin
                        rem_q      <= in_data;
                        frame_ok_q <= !range_err && (in_data != 8'd0);
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr_q;
                        mem_data <= in_data;
                        addr_q   <= addr_q + 1'b1;
                        rem_q    <= rem_q - 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (xfer) rem_q <= rem_q - 8'd1;
                end
                S_DONE: begin
                    if (frame_ok_q) cfg_loaded <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A new range error on the same edge as clr_err keeps err set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == S_LEN && xfer && range_err) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

endmodule
